volume_sequencer: RTL and testbench



---
 rtl/volume_sequencer_pkg.sv | 22 ++
 rtl/volume_stepper.sv | 62 ++++++
 rtl/volume_sequencer.sv | 132 +++++++++++++
 tb/tb_volume_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/volume_sequencer_pkg.sv
// rtl/volume_sequencer_pkg.sv - shared states, source select and width for the volume sequencer
package volume_sequencer_pkg;

    localparam int VOL_WIDTH = 8;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_MUTED     = 3'd4;

    typedef enum logic {
        SRC_USB  = 1'b0,
        SRC_KNOB = 1'b1
    } src_e;

    // Ramping down and sitting muted both drive the channels toward silence.
    function automatic logic forces_zero(input logic [2:0] st);
        return (st == ST_RAMP_DOWN) || (st == ST_MUTED);
    endfunction

endpackage

// File: rtl/volume_stepper.sv
// rtl/volume_stepper.sv - one channel's volume index, slewed toward its target by at most STEP per tick
module volume_stepper
    import volume_sequencer_pkg::*;
#(
    parameter int WIDTH = VOL_WIDTH,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             step_ena_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             zero_now_i,
    input  logic             zero_next_i,
    output logic [WIDTH-1:0] index_o,
    output logic             at_target_o
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [WIDTH-1:0] index_q;
    logic [WIDTH-1:0] index_d;
    logic [WIDTH-1:0] step_tgt;
    logic [WIDTH-1:0] cur_tgt;
    logic [WIDTH-1:0] diff;

    // Next index: cleared while off, otherwise a clipped step toward the next-state target.
    always_comb begin
        step_tgt = zero_next_i ? '0 : target_i;
        index_d  = index_q;
        diff     = '0;
        if (clear_i) begin
            index_d = '0;
        end else if (step_ena_i) begin
            if (step_tgt > index_q) begin
                diff    = step_tgt - index_q;
                index_d = index_q + ((diff < STEP_V) ? diff : STEP_V);
            end else if (step_tgt < index_q) begin
                diff    = index_q - step_tgt;
                index_d = index_q - ((diff < STEP_V) ? diff : STEP_V);
            end
        end
    end

    // Index register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    // At-target uses the current state's target so it never depends on the next state.
    always_comb begin
        cur_tgt     = zero_now_i ? '0 : target_i;
        at_target_o = (index_q == cur_tgt);
    end

    assign index_o = index_q;

endmodule

// File: rtl/volume_sequencer.sv
// rtl/volume_sequencer.sv - arbitrates volume sources, sequences mute/stream ramps and gates the PWM
module volume_sequencer
    import volume_sequencer_pkg::*;
#(
    parameter int WIDTH = VOL_WIDTH,
    parameter int STEP  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               sample_ena_i,
    input  logic               active_i,
    input  logic               mute_i,
    input  logic [2*WIDTH-1:0] volume_usb_i,
    input  logic [WIDTH-1:0]   knob_i,
    output logic [2*WIDTH-1:0] volume_index_o,
    output logic               output_enable_o,
    output logic               busy_o,
    output logic [2:0]         state_o
);

    logic [2*WIDTH-1:0] usb_q;
    logic [2*WIDTH-1:0] usb_prev_q;
    logic [WIDTH-1:0]   knob_q;
    logic [WIDTH-1:0]   knob_prev_q;
    src_e               src_q;
    src_e               src_d;
    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic               oe_q;

    logic [WIDTH-1:0]   target [2];
    logic [WIDTH-1:0]   index  [2];
    logic [1:0]         at_tgt;
    logic               all_at;
    logic               all_zero;

    // Register the sources twice so a change is seen as a difference between the two copies.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            usb_q       <= '0;
            usb_prev_q  <= '0;
            knob_q      <= '0;
            knob_prev_q <= '0;
            src_q       <= SRC_USB;
        end else begin
            usb_q       <= volume_usb_i;
            usb_prev_q  <= usb_q;
            knob_q      <= knob_i;
            knob_prev_q <= knob_q;
            src_q       <= src_d;
        end
    end

    // Most recent mover owns the target; USB wins a tie.
    always_comb begin
        src_d = src_q;
        if (usb_q != usb_prev_q) begin
            src_d = SRC_USB;
        end else if (knob_q != knob_prev_q) begin
            src_d = SRC_KNOB;
        end
    end

    // Per-channel base target from the selected source.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            target[ch] = (src_q == SRC_USB) ? usb_prev_q[ch*WIDTH +: WIDTH] : knob_prev_q;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        volume_stepper #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) u_stepper (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .clear_i     (state_d == ST_OFF),
            .step_ena_i  (sample_ena_i),
            .target_i    (target[ch]),
            .zero_now_i  (forces_zero(state_q)),
            .zero_next_i (forces_zero(state_d)),
            .index_o     (index[ch]),
            .at_target_o (at_tgt[ch])
        );
    end

    // Sequencer next state; ramps are always completed through RAMP_DOWN before going off.
    always_comb begin
        all_at   = &at_tgt;
        all_zero = (index[0] == '0) && (index[1] == '0);
        state_d  = state_q;
        case (state_q)
            ST_OFF: begin
                if (active_i && !mute_i) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (mute_i || !active_i) state_d = ST_RAMP_DOWN;
                else if (all_at)         state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mute_i || !active_i) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (active_i && !mute_i) state_d = ST_RAMP_UP;
                else if (all_zero)       state_d = active_i ? ST_MUTED : ST_OFF;
            end
            ST_MUTED: begin
                if (!active_i)   state_d = ST_OFF;
                else if (!mute_i) state_d = ST_RAMP_UP;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // State and output enable; the enable follows the next state so it moves with the transition.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_OFF;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            oe_q    <= (state_d != ST_OFF);
        end
    end

    assign volume_index_o  = {index[1], index[0]};
    assign output_enable_o = oe_q;
    assign busy_o          = ~all_at;
    assign state_o         = state_q;

endmodule

// File: tb/tb_volume_sequencer.sv
// tb/tb_volume_sequencer.sv - scoreboard bench for volume_sequencer ramps, arbitration and gating
module tb_volume_sequencer;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_UP    = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DOWN  = 3'd3;
    localparam logic [2:0] S_MUTED = 3'd4;

    typedef struct packed {
        logic [7:0] i1;
        logic [7:0] i0;
    } pair_t;

    logic        clk;
    logic        reset;
    logic        sample_ena;
    logic        active;
    logic        mute;
    logic [15:0] volume_usb;
    logic [7:0]  remote_level;
    logic [15:0] volume_index;
    logic        output_enable;
    logic        busy;
    logic [2:0]  state;

    int    n_checks;
    int    n_fail;
    pair_t sb[$];

    volume_sequencer #(.WIDTH(8), .STEP(1)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .sample_ena_i    (sample_ena),
        .active_i        (active),
        .mute_i          (mute),
        .volume_usb_i    (volume_usb),
        .knob_i          (remote_level),
        .volume_index_o  (volume_index),
        .output_enable_o (output_enable),
        .busy_o          (busy),
        .state_o         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_tick(output logic [15:0] idx, output logic b, output logic oe);
        @(negedge clk);
        sample_ena = 1'b1;
        @(negedge clk);
        sample_ena = 1'b0;
        idx = volume_index;
        b   = busy;
        oe  = output_enable;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_state(input string name, input logic [2:0] exp_st);
        n_checks++;
        if (state !== exp_st) begin
            n_fail++;
            $display("FAIL %s: state got %0d expected %0d", name, state, exp_st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_ena = 1'b0; active = 1'b0; mute = 1'b0;
        volume_usb = '0; remote_level = '0;
        repeat (3) @(negedge clk);
        check_state("reset_state", S_OFF);
        n_checks++;
        if (volume_index !== 16'h0000) begin
            n_fail++; $display("FAIL reset_index: got %h expected 0000", volume_index);
        end
        n_checks++;
        if (output_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_oe: got %b expected 0", output_enable);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_ticks(input string name, input int n, input int s0, input int t0,
                             input int s1, input int t1);
        logic [15:0] idx;
        logic        b, oe;
        pair_t       e, got;
        int          v0, v1;
        for (int k = 1; k <= n; k++) begin
            v0 = (t0 >= s0) ? ((s0 + k > t0) ? t0 : s0 + k) : ((s0 - k < t0) ? t0 : s0 - k);
            v1 = (t1 >= s1) ? ((s1 + k > t1) ? t1 : s1 + k) : ((s1 - k < t1) ? t1 : s1 - k);
            e.i0 = 8'(v0);
            e.i1 = 8'(v1);
            sb.push_back(e);
            do_tick(idx, b, oe);
            got = idx;
            e   = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s tick %0d: index got %h expected %h", name, k, got, e);
            end
        end
    endtask

    task automatic test_ramp_up();
        logic [15:0] idx;
        logic        b, oe;
        pair_t       e;
        volume_usb = {8'd100, 8'd200};
        repeat (3) @(negedge clk);
        active = 1'b1; mute = 1'b0;
        @(negedge clk);
        n_checks++;
        if (output_enable !== 1'b1) begin
            n_fail++; $display("FAIL ramp_up_oe: got %b expected 1", output_enable);
        end
        check_state("ramp_up_entry", S_UP);
        for (int k = 1; k <= 200; k++) begin
            e.i0 = 8'(k);
            e.i1 = 8'((k < 100) ? k : 100);
            sb.push_back(e);
            do_tick(idx, b, oe);
            e = sb.pop_front();
            n_checks++;
            if (idx !== e) begin
                n_fail++; $display("FAIL ramp_up tick %0d: index got %h expected %h", k, idx, e);
            end
            n_checks++;
            if (b !== (k < 200)) begin
                n_fail++; $display("FAIL ramp_up_busy tick %0d: got %b expected %b", k, b, (k < 200));
            end
        end
        check_state("ramp_up_run", S_RUN);
    endtask

    task automatic test_mute();
        mute = 1'b1;
        @(negedge clk);
        check_state("mute_entry", S_DOWN);
        run_ticks("mute_down", 200, 200, 0, 100, 0);
        check_state("muted", S_MUTED);
        n_checks++;
        if (output_enable !== 1'b1) begin
            n_fail++; $display("FAIL muted_oe: got %b expected 1", output_enable);
        end
        mute = 1'b0;
        run_ticks("unmute_up", 200, 0, 200, 0, 100);
        check_state("unmute_run", S_RUN);
    endtask

    task automatic test_remote();
        remote_level = 8'd50;
        repeat (2) @(negedge clk);
        run_ticks("remote", 150, 200, 50, 100, 50);
        check_state("remote_run", S_RUN);
    endtask

    task automatic test_usb_wins();
        volume_usb   = {8'd90, 8'd80};
        remote_level = 8'd10;
        repeat (2) @(negedge clk);
        run_ticks("usb_wins", 40, 50, 80, 50, 90);
        check_state("usb_wins_run", S_RUN);
    endtask

    task automatic test_drop_active();
        logic [15:0] idx;
        logic        b, oe;
        pair_t       e;
        volume_usb = {8'd200, 8'd200};
        repeat (2) @(negedge clk);
        run_ticks("to_full", 120, 80, 200, 90, 200);
        check_state("to_full_run", S_RUN);
        active = 1'b0;
        @(negedge clk);
        check_state("drop_entry", S_DOWN);
        for (int k = 1; k <= 200; k++) begin
            e.i0 = 8'(200 - k);
            e.i1 = 8'(200 - k);
            sb.push_back(e);
            do_tick(idx, b, oe);
            e = sb.pop_front();
            n_checks++;
            if (idx !== e) begin
                n_fail++; $display("FAIL drop tick %0d: index got %h expected %h", k, idx, e);
            end
            n_checks++;
            if (oe !== 1'b1) begin
                n_fail++; $display("FAIL drop_oe tick %0d: got %b expected 1", k, oe);
            end
        end
        check_state("drop_off", S_OFF);
        n_checks++;
        if (output_enable !== 1'b0) begin
            n_fail++; $display("FAIL drop_oe_off: got %b expected 0", output_enable);
        end
    endtask

    task automatic test_mute_toggle();
        logic [15:0] idx;
        logic        b, oe;
        pair_t       e;
        int          prev;
        prev   = 0;
        active = 1'b1;
        for (int k = 0; k < 24; k++) begin
            mute = ((k / 3) % 2) == 1;
            prev = mute ? ((prev == 0) ? 0 : prev - 1) : prev + 1;
            e.i0 = 8'(prev);
            e.i1 = 8'(prev);
            sb.push_back(e);
            do_tick(idx, b, oe);
            e = sb.pop_front();
            n_checks++;
            if (idx !== e) begin
                n_fail++; $display("FAIL mute_toggle tick %0d: index got %h expected %h", k, idx, e);
            end
        end
        check_state("toggle_muted", S_MUTED);
    endtask

    task automatic test_reset_mid_ramp();
        mute = 1'b0;
        run_ticks("pre_reset", 120, 0, 200, 0, 200);
        reset = 1'b1;
        @(negedge clk);
        check_state("mid_reset_state", S_OFF);
        n_checks++;
        if (volume_index !== 16'h0000) begin
            n_fail++; $display("FAIL mid_reset_index: got %h expected 0000", volume_index);
        end
        n_checks++;
        if (output_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_oe: got %b expected 0", output_enable);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ramp_up();
        test_mute();
        test_remote();
        test_usb_wins();
        test_drop_active();
        test_mute_toggle();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
